// File: rtl/prog_loader.sv
// Serial in-circuit programming loader: receives 6-bit host commands and data
// frames over a slow asynchronous serial clock and drives program-memory strobes.
module prog_loader #(
    parameter int ADDR_WIDTH  = 13,
    parameter int INSTR_WIDTH = 14,
    parameter int PROG_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_en_i,
    input  logic                   icsp_clk_i,
    input  logic                   icsp_din_i,
    output logic                   icsp_dout_o,
    output logic                   icsp_oe_o,
    output logic                   cpu_hold_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic                   mem_wr_en_o,
    output logic [INSTR_WIDTH-1:0] mem_wr_data_o,
    output logic                   mem_rd_en_o,
    input  logic [INSTR_WIDTH-1:0] mem_rd_data_i,
    output logic                   busy_o
);

    localparam int FRAME_BITS = INSTR_WIDTH + 2;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int WAIT_W     = $clog2(PROG_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(5);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(PROG_CYCLES - 1);

    localparam logic [5:0] CMD_LOAD_DATA  = 6'h02;
    localparam logic [5:0] CMD_READ_DATA  = 6'h04;
    localparam logic [5:0] CMD_INC_ADDR   = 6'h06;
    localparam logic [5:0] CMD_BEGIN_PROG = 6'h08;
    localparam logic [5:0] CMD_RESET_ADDR = 6'h16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA_IN,
        S_DATA_OUT,
        S_PROG_WAIT
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             clk_sync_q;
    logic [1:0]             din_sync_q;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [5:0]             cmd_sh_q, cmd_sh_d;
    logic                   cmd_rdy_q, cmd_rdy_d;
    logic [FRAME_BITS-1:0]  data_sh_q, data_sh_d;
    logic [INSTR_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                   cap_q, cap_d;

    logic                   sedge;
    logic                   din_bit;
    logic [FRAME_BITS-1:0]  rx_frame;
    logic                   wr_stb;
    logic                   rd_stb;

    // Both synchronizers have the same depth, so the data bit is aligned with its clock edge.
    assign sedge    = clk_sync_q[1] & ~clk_sync_q[2];
    assign din_bit  = din_sync_q[1];
    assign rx_frame = {din_bit, data_sh_q[FRAME_BITS-1:1]};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_sh_d   = cmd_sh_q;
        cmd_rdy_d  = 1'b0;
        data_sh_d  = data_sh_q;
        data_d     = data_q;
        addr_d     = addr_q;
        wait_cnt_d = wait_cnt_q;
        cap_d      = 1'b0;
        wr_stb     = 1'b0;
        rd_stb     = 1'b0;

        if (!prog_en_i) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            addr_d     = '0;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                    addr_d    = '0;
                end

                S_CMD: begin
                    if (cmd_rdy_q) begin
                        bit_cnt_d = '0;
                        case (cmd_sh_q)
                            CMD_LOAD_DATA: state_d = S_DATA_IN;
                            CMD_READ_DATA: begin
                                rd_stb    = 1'b1;
                                data_sh_d = '0;
                                cap_d     = 1'b1;
                                state_d   = S_DATA_OUT;
                            end
                            CMD_INC_ADDR: addr_d = addr_q + ADDR_WIDTH'(1);
                            CMD_BEGIN_PROG: begin
                                wr_stb     = 1'b1;
                                wait_cnt_d = '0;
                                state_d    = S_PROG_WAIT;
                            end
                            CMD_RESET_ADDR: addr_d = '0;
                            default: ;
                        endcase
                    end else if (sedge) begin
                        cmd_sh_d = {din_bit, cmd_sh_q[5:1]};
                        if (bit_cnt_q == CMD_LAST) begin
                            bit_cnt_d = '0;
                            cmd_rdy_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_DATA_IN: begin
                    if (sedge) begin
                        data_sh_d = rx_frame;
                        if (bit_cnt_q == FRAME_LAST) begin
                            data_d    = rx_frame[INSTR_WIDTH:1];
                            bit_cnt_d = '0;
                            state_d   = S_CMD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_DATA_OUT: begin
                    // Read data arrives one cycle after the strobe; frame it with zero start/stop bits.
                    if (cap_q) begin
                        data_sh_d = {1'b0, mem_rd_data_i, 1'b0};
                    end else if (sedge) begin
                        data_sh_d = {1'b0, data_sh_q[FRAME_BITS-1:1]};
                        if (bit_cnt_q == FRAME_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = S_CMD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_PROG_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_d = '0;
                        state_d    = S_CMD;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            clk_sync_q <= '0;
            din_sync_q <= '0;
            bit_cnt_q  <= '0;
            cmd_sh_q   <= '0;
            cmd_rdy_q  <= 1'b0;
            data_sh_q  <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            wait_cnt_q <= '0;
            cap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= {clk_sync_q[1:0], icsp_clk_i};
            din_sync_q <= {din_sync_q[0], icsp_din_i};
            bit_cnt_q  <= bit_cnt_d;
            cmd_sh_q   <= cmd_sh_d;
            cmd_rdy_q  <= cmd_rdy_d;
            data_sh_q  <= data_sh_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            cap_q      <= cap_d;
        end
    end

    assign icsp_oe_o     = (state_q == S_DATA_OUT);
    assign icsp_dout_o   = icsp_oe_o & data_sh_q[0];
    assign cpu_hold_o    = (state_q != S_IDLE);
    assign busy_o        = (state_q == S_PROG_WAIT);
    assign mem_addr_o    = addr_q;
    assign mem_wr_data_o = data_q;
    // Strobes decode straight from the command cycle; reset masks them immediately.
    assign mem_wr_en_o   = wr_stb & ~rst;
    assign mem_rd_en_o   = rd_stb & ~rst;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus random command
// traffic compared against a behavioural address/latch/memory model.
module tb_prog_loader;

    localparam int AW    = 5;   // small address space so the wrap case is reachable quickly
    localparam int IW    = 14;
    localparam int PC    = 64;
    localparam int DEPTH = 1 << AW;

    localparam logic [5:0] C_LOAD  = 6'h02;
    localparam logic [5:0] C_READ  = 6'h04;
    localparam logic [5:0] C_INC   = 6'h06;
    localparam logic [5:0] C_PROG  = 6'h08;
    localparam logic [5:0] C_RADDR = 6'h16;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_en;
    logic          icsp_clk;
    logic          icsp_din;
    logic          icsp_dout;
    logic          icsp_oe;
    logic          cpu_hold;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [IW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [IW-1:0] mem_rd_data = '0;
    logic          busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    prog_loader #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .PROG_CYCLES(PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_en_i    (prog_en),
        .icsp_clk_i   (icsp_clk),
        .icsp_din_i   (icsp_din),
        .icsp_dout_o  (icsp_dout),
        .icsp_oe_o    (icsp_oe),
        .cpu_hold_o   (cpu_hold),
        .mem_addr_o   (mem_addr),
        .mem_wr_en_o  (mem_wr_en),
        .mem_wr_data_o(mem_wr_data),
        .mem_rd_en_o  (mem_rd_en),
        .mem_rd_data_i(mem_rd_data),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Program memory attached to the DUT, plus strobe/busy observation.
    logic [IW-1:0] env_mem [DEPTH];
    int wr_addr_log[$];
    int wr_data_log[$];
    int wr_busy_log[$];
    int busy_runs[$];
    int busy_run       = 0;
    int rd_pulses      = 0;
    int strobe_overlap = 0;

    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_addr_log.push_back(int'(mem_addr));
            wr_data_log.push_back(int'(mem_wr_data));
            wr_busy_log.push_back(int'(busy));
            env_mem[mem_addr] = mem_wr_data;
        end
        if (mem_rd_en) rd_pulses++;
        if (mem_wr_en && mem_rd_en) strobe_overlap++;
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            busy_runs.push_back(busy_run);
            busy_run = 0;
        end
    end

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= env_mem[mem_addr];
        else           mem_rd_data <= IW'($urandom);
    end

    // Reference model: address counter, data latch and expected memory contents.
    logic [IW-1:0] ref_mem   [DEPTH];
    bit            ref_valid [DEPTH];
    int            ref_addr;
    logic [IW-1:0] ref_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({icsp_dout, icsp_oe, cpu_hold, mem_wr_en, mem_rd_en, busy, mem_addr, mem_wr_data});
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        icsp_din = b;
        cycles(2);
        icsp_clk = 1'b1;
        cycles(9);
        icsp_clk = 1'b0;
        cycles(9);
    endtask

    task automatic send_cmd(input logic [5:0] c);
        for (int i = 0; i < 6; i++) send_bit(c[i]);
    endtask

    task automatic load_data(input logic [IW-1:0] d);
        logic [IW+1:0] f;
        f = {1'($urandom), d, 1'($urandom)};
        send_cmd(C_LOAD);
        for (int i = 0; i < IW + 2; i++) send_bit(f[i]);
        ref_data = d;
    endtask

    task automatic do_inc();
        send_cmd(C_INC);
        ref_addr = (ref_addr + 1) % DEPTH;
    endtask

    task automatic do_raddr();
        send_cmd(C_RADDR);
        ref_addr = 0;
    endtask

    task automatic do_prog(input string tag, input int noise);
        int n0;
        int r0;
        n0 = wr_addr_log.size();
        r0 = busy_runs.size();
        send_cmd(C_PROG);
        for (int p = 0; p < noise; p++) begin
            icsp_din = 1'($urandom);
            icsp_clk = 1'b1;
            cycles(3);
            icsp_clk = 1'b0;
            cycles(2);
        end
        if (noise > 0) check({tag, "_busy_during_noise"}, 32'(busy), 32'd1);
        for (int i = 0; i < 4 * PC && busy; i++) @(negedge clk);
        cycles(2);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_wr_pulses"}, wr_addr_log.size() - n0, 32'd1);
        if (wr_addr_log.size() > n0) begin
            check({tag, "_wr_addr"}, wr_addr_log[n0], ref_addr);
            check({tag, "_wr_data"}, wr_data_log[n0], 32'(ref_data));
            check({tag, "_busy_at_strobe"}, wr_busy_log[n0], 32'd0);
        end
        check({tag, "_busy_runs"}, busy_runs.size() - r0, 32'd1);
        if (busy_runs.size() > r0) check({tag, "_busy_len"}, busy_runs[r0], PC);
        ref_mem[ref_addr]   = ref_data;
        ref_valid[ref_addr] = 1'b1;
    endtask

    task automatic do_read(input string tag);
        int            p0;
        logic [IW+1:0] exp_f;
        logic [IW+1:0] obs_f;
        logic          oe_all;
        p0     = rd_pulses;
        exp_f  = {1'b0, ref_mem[ref_addr], 1'b0};
        obs_f  = '0;
        oe_all = 1'b1;
        send_cmd(C_READ);
        check({tag, "_rd_pulses"}, rd_pulses - p0, 32'd1);
        for (int k = 0; k < IW + 2; k++) begin
            obs_f[k] = icsp_dout;
            oe_all   = oe_all & icsp_oe;
            send_bit(1'($urandom));
        end
        check({tag, "_frame"}, 32'(obs_f), 32'(exp_f));
        check({tag, "_oe_during"}, 32'(oe_all), 32'd1);
        check({tag, "_oe_after"}, 32'(icsp_oe), 32'd0);
    endtask

    initial begin
        logic [5:0] bogus;
        rst      = 1'b1;
        prog_en  = 1'b0;
        icsp_clk = 1'b0;
        icsp_din = 1'b0;
        ref_addr = 0;
        ref_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_valid[i] = 1'b0;
            ref_mem[i]   = '0;
        end
        cycles(4);
        check("reset_outputs", outs(), 32'd0);
        rst = 1'b0;
        cycles(2);
        check("idle_no_hold", 32'(cpu_hold), 32'd0);
        prog_en = 1'b1;
        cycles(2);
        check("hold_on_enable", 32'(cpu_hold), 32'd1);

        // Load and program at address 0.
        load_data(14'h2ABC);
        do_prog("wr_2abc", 0);

        // Address wrap from all-ones to zero.
        do_raddr();
        repeat (DEPTH - 1) do_inc();
        check("addr_top", 32'(mem_addr), ref_addr);
        load_data(14'h0001);
        do_prog("wr_top", 0);
        do_inc();
        check("addr_wrapped", 32'(mem_addr), ref_addr);
        load_data(14'h0002);
        do_prog("wr_wrap", 0);

        // Read-back of all-ones data at address 5.
        do_raddr();
        repeat (5) do_inc();
        load_data(14'h3FFF);
        do_prog("wr_3fff", 0);
        do_read("read_3fff");

        // Serial clocks during the programming wait must be ignored.
        do_prog("wr_noise", 8);
        load_data(14'h0123);
        do_prog("wr_after_noise", 0);

        // Dropping prog_en mid data frame.
        send_cmd(C_LOAD);
        for (int i = 0; i < 9; i++) send_bit(1'($urandom));
        prog_en = 1'b0;
        cycles(2);
        check("abort_idle", 32'({cpu_hold, icsp_oe, busy, mem_addr}), 32'd0);
        ref_addr = 0;
        prog_en  = 1'b1;
        cycles(2);
        check("abort_rehold", 32'(cpu_hold), 32'd1);
        do_inc();
        do_prog("wr_after_abort", 0);

        // Random command traffic.
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 5))
                0: load_data(IW'($urandom));
                1: do_inc();
                2: do_raddr();
                3: do_prog("rnd_prog", 0);
                4: if (ref_valid[ref_addr]) do_read("rnd_read");
                   else do_prog("rnd_prog", 0);
                default: begin
                    do bogus = 6'($urandom);
                    while (bogus inside {C_LOAD, C_READ, C_INC, C_PROG, C_RADDR});
                    send_cmd(bogus);
                    check("rnd_bogus_addr", 32'(mem_addr), ref_addr);
                    check("rnd_bogus_idle", 32'({busy, icsp_oe}), 32'd0);
                end
            endcase
        end

        // Reset in the middle of a read-back.
        send_cmd(C_READ);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        rst = 1'b1;
        cycles(1);
        check("rst_mid_read", outs(), 32'd0);
        rst      = 1'b0;
        ref_addr = 0;
        ref_data = '0;
        cycles(3);
        check("rst_rehold", 32'(cpu_hold), 32'd1);
        do_prog("wr_after_rst", 0);

        check("no_strobe_overlap", strobe_overlap, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, program-memory word-address width.
REQ-002 Parameter INSTR_WIDTH, default 14, instruction word width.
REQ-003 Parameter PROG_CYCLES, default 64, clk cycles of busy time after each write.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 prog_en  input  1  programming-mode enable; low forces the block idle.
REQ-007 icsp_clk  input  1  asynchronous serial clock from the host programmer.
REQ-008 icsp_din  input  1  asynchronous serial data from the host.
REQ-009 icsp_dout  output  1  serial read-back data to the host.
REQ-010 icsp_oe  output  1  high while icsp_dout is driven.
REQ-011 cpu_hold  output  1  high while in programming mode; stalls the core fetch.
REQ-012 mem_addr  output  ADDR_WIDTH  program-memory address for reads and writes.
REQ-013 mem_wr_en  output  1  one-cycle program-memory write strobe.
REQ-014 mem_wr_data  output  INSTR_WIDTH  write data.
REQ-015 mem_rd_en  output  1  one-cycle program-memory read strobe.
REQ-016 mem_rd_data  input  INSTR_WIDTH  read data, valid the cycle after mem_rd_en.
REQ-017 busy  output  1  high during the post-write PROG_WAIT period.

Function
REQ-018 icsp_clk and icsp_din each pass through a 2-flop synchronizer; one rising-edge pulse (sedge) is generated per synchronized low-to-high transition; each serial bit is the synchronized icsp_din at sedge.
REQ-019 The host guarantees icsp_clk high and low phases each of at least 8 clk cycles.
REQ-020 States: IDLE, CMD, DATA_IN, DATA_OUT, PROG_WAIT.
REQ-021 IDLE: cpu_hold=0 and the address counter is 0; prog_en=1 moves to CMD next cycle and sets cpu_hold=1.
REQ-022 CMD: 6 bits are shifted in LSB first, one per sedge; after the 6th bit the command is decoded in the following cycle.
REQ-023 Command 0x02 (Load Data) goes to DATA_IN.
REQ-024 Command 0x04 (Read Data) pulses mem_rd_en with mem_addr=address and goes to DATA_OUT.
REQ-025 Command 0x06 (Increment Address) sets address to address+1 mod 2^ADDR_WIDTH, so all-ones wraps to 0, and stays in CMD.
REQ-026 Command 0x08 (Begin Programming) pulses mem_wr_en for one cycle with mem_addr=address and mem_wr_data=data latch, then goes to PROG_WAIT.
REQ-027 Command 0x16 (Reset Address) sets address to 0 and stays in CMD.
REQ-028 Any other command value is ignored; the block stays in CMD with the bit counter cleared.
REQ-029 DATA_IN: a 16-bit frame is received LSB first as start bit, INSTR_WIDTH data bits, stop bit; only the data bits load the data latch; start and stop values are don't-care; the block returns to CMD after the 16th sedge.
REQ-030 DATA_OUT: the frame {0, mem_rd_data, 0} is loaded, start bit first; mem_rd_data is captured the cycle after mem_rd_en.
REQ-031 DATA_OUT: icsp_oe=1 and icsp_dout presents frame bit k after k sedges (k=0..15); icsp_oe drops and the block returns to CMD on the 16th sedge.
REQ-032 PROG_WAIT: busy=1 for exactly PROG_CYCLES cycles, then the block returns to CMD; sedges during PROG_WAIT are discarded and do not advance any counter.
REQ-033 prog_en deasserting in any state forces IDLE the next cycle and clears the bit counter, address, icsp_oe, busy and cpu_hold; the data latch is retained.
REQ-034 mem_wr_en and mem_rd_en are never high in the same cycle, and neither is high outside its defined pulse.

Reset
REQ-035 On rst, in the same clock edge: state=IDLE; address, data latch, shift registers and counters are 0; cpu_hold, mem_wr_en, mem_rd_en, icsp_oe, icsp_dout and busy are 0; mem_addr and mem_wr_data are 0.
REQ-036 rst takes priority over prog_en and over every in-progress transfer or PROG_WAIT count.

Verification
REQ-037 prog_en=1, Load Data 0x2ABC, Begin Programming -> one mem_wr_en pulse with mem_addr=0 and mem_wr_data=0x2ABC, then busy high for exactly 64 cycles.
REQ-038 Reset Address, then 0x1FFF Increment Address commands, Load Data 0x0001, Begin Programming, Increment Address, Load Data 0x0002, Begin Programming -> writes occur at 0x1FFF, then 0x0000 (wrap).
REQ-039 Read Data with mem_rd_data=0x3FFF at address 5 -> icsp_oe high for 16 bit times; icsp_dout sequence 0, fourteen 1s, 0.
REQ-040 Eight icsp_clk pulses issued during PROG_WAIT, then Load Data 0x0123 -> the pulses are ignored and the data latch is 0x0123.
REQ-041 prog_en dropped after 9 of 16 DATA_IN bits, then reasserted and Increment Address issued -> IDLE with cpu_hold=0 in between; next write goes to address 1.
REQ-042 rst asserted mid-DATA_OUT -> icsp_oe=0, busy=0, cpu_hold=0 next cycle; all outputs at their reset values.
